// File: rtl/alu_seq_pkg.sv
// Purpose  : shared encodings for the ALU operand sequencer (op kinds, ALU functions, FSM states).
// Latency  : n/a (types, constants and pure helper functions only).
// Backpress: n/a.
// Ports    : none. Build option DECIMAL_MODE_EN adds the DADJ state to seq_state_e.
package alu_seq_pkg;

    localparam int KIND_W  = 3;
    localparam int FN_W    = 3;
    localparam int STATE_W = 3;

    typedef enum logic [KIND_W-1:0] {
        OP_ADC  = 3'd0,
        OP_SBC  = 3'd1,
        OP_AND  = 3'd2,
        OP_ORA  = 3'd3,
        OP_EOR  = 3'd4,
        OP_INC  = 3'd5,
        OP_IDX  = 3'd6,
        OP_RSVD = 3'd7
    } op_kind_e;

    typedef enum logic [FN_W-1:0] {
        FN_SUM = 3'd0,
        FN_AND = 3'd1,
        FN_OR  = 3'd2,
        FN_EOR = 3'd3
    } alu_fn_e;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE      = 3'd0,
        ST_LOAD      = 3'd1,
        ST_EXEC      = 3'd2,
        ST_WRITE     = 3'd3,
        ST_FIX_LOAD  = 3'd4,
        ST_FIX_EXEC  = 3'd5,
        ST_FIX_WRITE = 3'd6
`ifdef DECIMAL_MODE_EN
        ,
        ST_DADJ      = 3'd7
`endif
    } seq_state_e;

    // ALU function for the main EXEC pass of a given kind.
    function automatic alu_fn_e kind_fn(input op_kind_e kind);
        case (kind)
            OP_AND:  return FN_AND;
            OP_ORA:  return FN_OR;
            OP_EOR:  return FN_EOR;
            default: return FN_SUM;
        endcase
    endfunction

    // Carry-in for the main EXEC pass; only ADC/SBC honour the latched P.C.
    function automatic logic kind_cin(input op_kind_e kind, input logic c_flag);
        case (kind)
            OP_ADC, OP_SBC: return c_flag;
            OP_INC:         return 1'b1;
            default:        return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/alu_operand_sequencer_if.sv
// Purpose  : decoder/ALU-facing bundle of the operand sequencer (handshake, flags, strobes).
// Latency  : n/a (wires only).
// Backpress: op_valid/op_ready handshake; op_ready low while an op is in flight or rdy=0.
// Ports    : master = sequencer side (drives op_ready and all strobes),
//            slave  = decoder/ALU side (drives op_valid, op_kind, flags, alu_cout).
interface alu_operand_sequencer_if;

    logic       op_valid;
    logic       op_ready;
    logic [2:0] op_kind;
    logic       carry_flag;
    logic       decimal_flag;
    logic       alu_cout;

    logic       SB_ADD;
    logic       O_ADD;
    logic       DB_ADD;
    logic       NDB_ADD;
    logic       ADL_ADD;
    logic [2:0] alu_fn;
    logic       alu_cin;
    logic       ADD_SB;
    logic       ADD_ADL;
    logic       ADD_ADH;
    logic       decimal_adj;
    logic       page_cross;
    logic       illegal_op;
    logic       done;

    modport master (
        input  op_valid, op_kind, carry_flag, decimal_flag, alu_cout,
        output op_ready, SB_ADD, O_ADD, DB_ADD, NDB_ADD, ADL_ADD,
               alu_fn, alu_cin, ADD_SB, ADD_ADL, ADD_ADH,
               decimal_adj, page_cross, illegal_op, done
    );

    modport slave (
        output op_valid, op_kind, carry_flag, decimal_flag, alu_cout,
        input  op_ready, SB_ADD, O_ADD, DB_ADD, NDB_ADD, ADL_ADD,
               alu_fn, alu_cin, ADD_SB, ADD_ADL, ADD_ADH,
               decimal_adj, page_cross, illegal_op, done
    );

endinterface

// File: rtl/alu_operand_sequencer.sv
// Purpose  : steps one ALU op per handshake through LOAD->EXEC->WRITE (+ IDX page fix-up pass).
// Latency  : accept->done 3 cycles; 6 for IDX with page cross; 4 for decimal ADC/SBC.
// Backpress: one op in flight; op_ready only in IDLE; rdy=0 freezes state and gates all strobes.
// Ports    : clk, reset (sync, active-high), rdy (global stall), io_bus (alu_operand_sequencer_if.master).
// Build    : DECIMAL_MODE_EN inserts a DADJ (BCD adjust) cycle for ADC/SBC with P.D set.
import alu_seq_pkg::*;

module alu_operand_sequencer (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           rdy,
    alu_operand_sequencer_if.master        io_bus
);

    seq_state_e r_state;
    op_kind_e   r_kind;
    logic       r_c;
    logic       r_cross;
    alu_fn_e    r_alu_fn;
    logic       r_alu_cin;

    logic       w_idle;
    logic       w_accept;
    logic       w_is_idx;
    logic       w_dadj_needed;
    op_kind_e   w_kind_in;

`ifdef DECIMAL_MODE_EN
    logic       r_d;
    assign w_dadj_needed = r_d && ((r_kind == OP_ADC) || (r_kind == OP_SBC));
`else
    logic       w_unused_decimal;
    assign w_unused_decimal = io_bus.decimal_flag;
    assign w_dadj_needed    = 1'b0;
`endif

    assign w_idle    = (r_state == ST_IDLE);
    assign w_kind_in = op_kind_e'(io_bus.op_kind);
    assign w_accept  = io_bus.op_valid && io_bus.op_ready;
    assign w_is_idx  = (r_kind == OP_IDX);

    assign io_bus.op_ready = w_idle && rdy;
    assign io_bus.alu_fn   = r_alu_fn;
    assign io_bus.alu_cin  = r_alu_cin;

    // Reserved kind is consumed by the handshake but never leaves IDLE.
    // Gating with reset keeps the pulse quiet while the block is held in reset.
    assign io_bus.illegal_op = w_accept && !reset && (w_kind_in == OP_RSVD);

    // State register. alu_fn/alu_cin are loaded on the edge into (FIX_)EXEC so
    // they are stable through the whole EXEC cycle and simply hold elsewhere.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= ST_IDLE;
            r_kind    <= OP_ADC;
            r_c       <= 1'b0;
            r_cross   <= 1'b0;
            r_alu_fn  <= FN_SUM;
            r_alu_cin <= 1'b0;
`ifdef DECIMAL_MODE_EN
            r_d       <= 1'b0;
`endif
        end else if (rdy) begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_kind <= w_kind_in;
                        r_c    <= io_bus.carry_flag;
`ifdef DECIMAL_MODE_EN
                        r_d    <= io_bus.decimal_flag;
`endif
                        if (w_kind_in != OP_RSVD) begin
                            r_state <= ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    r_alu_fn  <= kind_fn(r_kind);
                    r_alu_cin <= kind_cin(r_kind, r_c);
                    r_state   <= ST_EXEC;
                end
                ST_EXEC: begin
                    // Low-byte carry of the index add decides the fix-up pass.
                    r_cross <= w_is_idx && io_bus.alu_cout;
`ifdef DECIMAL_MODE_EN
                    r_state <= w_dadj_needed ? ST_DADJ : ST_WRITE;
`else
                    r_state <= ST_WRITE;
`endif
                end
`ifdef DECIMAL_MODE_EN
                ST_DADJ: begin
                    r_state <= ST_WRITE;
                end
`endif
                ST_WRITE: begin
                    r_state <= (w_is_idx && r_cross) ? ST_FIX_LOAD : ST_IDLE;
                end
                ST_FIX_LOAD: begin
                    // High byte: 0 + DB + 1 propagates the page carry.
                    r_alu_fn  <= FN_SUM;
                    r_alu_cin <= 1'b1;
                    r_state   <= ST_FIX_EXEC;
                end
                ST_FIX_EXEC: begin
                    r_state <= ST_FIX_WRITE;
                end
                ST_FIX_WRITE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Strobe decode: registered state qualified by rdy, so a stall silences
    // every load/write strobe without disturbing the sequence.
    always_comb begin
        io_bus.SB_ADD      = 1'b0;
        io_bus.O_ADD       = 1'b0;
        io_bus.DB_ADD      = 1'b0;
        io_bus.NDB_ADD     = 1'b0;
        io_bus.ADL_ADD     = 1'b0;
        io_bus.ADD_SB      = 1'b0;
        io_bus.ADD_ADL     = 1'b0;
        io_bus.ADD_ADH     = 1'b0;
        io_bus.decimal_adj = 1'b0;
        io_bus.done        = 1'b0;
        io_bus.page_cross  = 1'b0;
        if (rdy) begin
            case (r_state)
                ST_LOAD: begin
                    io_bus.O_ADD   = (r_kind == OP_INC);
                    io_bus.SB_ADD  = (r_kind != OP_INC);
                    io_bus.NDB_ADD = (r_kind == OP_SBC);
                    io_bus.ADL_ADD = w_is_idx;
                    io_bus.DB_ADD  = (r_kind != OP_SBC) && !w_is_idx;
                end
`ifdef DECIMAL_MODE_EN
                ST_DADJ: begin
                    io_bus.decimal_adj = 1'b1;
                end
`endif
                ST_WRITE: begin
                    io_bus.ADD_SB  = !w_is_idx;
                    io_bus.ADD_ADL = w_is_idx;
                    io_bus.done    = !(w_is_idx && r_cross);
                end
                ST_FIX_LOAD: begin
                    io_bus.O_ADD  = 1'b1;
                    io_bus.DB_ADD = 1'b1;
                end
                ST_FIX_WRITE: begin
                    io_bus.ADD_ADH    = 1'b1;
                    io_bus.done       = 1'b1;
                    io_bus.page_cross = 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    // Only consulted in the decimal build; keeps the default build free of a dangling net.
    logic w_unused_dadj;
    assign w_unused_dadj = w_dadj_needed;

endmodule
